// File: rtl/fifo_word_assembler_pkg.sv
// Shared constants, state encoding and byte-lane helper for the FIFO word assembler.
package fifo_word_assembler_pkg;

  localparam int MARKER_BIT = 8;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Places a byte into the little-endian partial word (lanes 0..2 only).
  function automatic logic [23:0] put_byte(input logic [23:0] acc,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [23:0] r;
    r = acc;
    case (idx)
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fifo_word_assembler.sv
// Pops marker-framed bytes from the 9-bit FIFO and hands little-endian 32-bit
// words to the fetch path over valid/ready, flagging and recovering from framing loss.
module fifo_word_assembler
  import fifo_word_assembler_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_I,
  input  logic             reset_I,
  input  logic [8:0]       fifo_data_I,
  input  logic             fifo_empty_I,
  output logic             fifo_pop_O,
  output logic [31:0]      word_O,
  output logic             word_valid_O,
  input  logic             word_ready_I,
  output logic             sync_err_O,
  output logic [CNT_W-1:0] word_cnt_O
);

  state_t           state_r;
  logic [1:0]       byte_idx_r;
  logic             pend_r;
  logic [23:0]      partial_r;
  logic [31:0]      word_r;
  logic             valid_r;
  logic             err_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pop_s;
  logic             marker_s;
  logic [7:0]       byte_s;

  assign marker_s = fifo_data_I[MARKER_BIT];
  assign byte_s   = fifo_data_I[BYTE_W-1:0];

  // Pop request; withheld on the last byte of a word so nothing is in flight when it completes.
  always_comb begin
    pop_s = 1'b0;
    if (reset_I && !fifo_empty_I && !valid_r && !(pend_r && byte_idx_r == LAST_IDX)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Framing state machine, word assembly, handshake and delivered-word counter.
  always_ff @(posedge clk_I or negedge reset_I) begin
    if (!reset_I) begin
      state_r    <= HUNT;
      byte_idx_r <= 2'd0;
      pend_r     <= 1'b0;
      partial_r  <= 24'h0;
      word_r     <= 32'h0;
      valid_r    <= 1'b0;
      err_r      <= 1'b0;
      cnt_r      <= '0;
    end else begin
      pend_r <= pop_s;
      err_r  <= 1'b0;
      case (state_r)
        HUNT: begin
          if (pend_r) begin
            if (marker_s) begin
              partial_r  <= {16'h0, byte_s};
              byte_idx_r <= 2'd1;
              state_r    <= COLLECT;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (pend_r) begin
            if (marker_s) begin
              // Early marker: drop the partial word and restart from this byte.
              err_r      <= 1'b1;
              partial_r  <= {16'h0, byte_s};
              byte_idx_r <= 2'd1;
            end else if (byte_idx_r == LAST_IDX) begin
              word_r     <= {byte_s, partial_r};
              valid_r    <= 1'b1;
              byte_idx_r <= 2'd0;
              state_r    <= HOLD;
            end else begin
              partial_r  <= put_byte(partial_r, byte_idx_r, byte_s);
              byte_idx_r <= byte_idx_r + 2'd1;
            end
          end
        end
        HOLD: begin
          if (word_ready_I) begin
            valid_r <= 1'b0;
            cnt_r   <= cnt_r + CNT_W'(1);
            state_r <= HUNT;
          end
        end
        default: begin
          state_r    <= HUNT;
          byte_idx_r <= 2'd0;
          valid_r    <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_pop_O   = pop_s;
  assign word_O       = word_r;
  assign word_valid_O = valid_r;
  assign sync_err_O   = err_r;
  assign word_cnt_O   = cnt_r;

endmodule

// File: tb/tb_fifo_word_assembler.sv
// Self-checking bench: bench-side FIFO, framing-rule scoreboard and directed/random scenarios.
module tb_fifo_word_assembler;

  logic        clk = 1'b0;
  logic        reset_I;
  logic [8:0]  fifo_data_I;
  logic        fifo_empty_I;
  logic        fifo_pop_O;
  logic [31:0] word_O;
  logic        word_valid_O;
  logic        word_ready_I;
  logic        sync_err_O;
  logic [15:0] word_cnt_O;

  always #5 clk = ~clk;

  fifo_word_assembler #(.CNT_W(16)) dut (
    .clk_I        (clk),
    .reset_I      (reset_I),
    .fifo_data_I  (fifo_data_I),
    .fifo_empty_I (fifo_empty_I),
    .fifo_pop_O   (fifo_pop_O),
    .word_O       (word_O),
    .word_valid_O (word_valid_O),
    .word_ready_I (word_ready_I),
    .sync_err_O   (sync_err_O),
    .word_cnt_O   (word_cnt_O)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [8:0]  fifo_q[$];
  logic [31:0] exp_q[$];
  int          exp_err, err_seen, hs_total;
  int          rdy_mode, emp_mode;
  bit          emp_phase, last_pop, prev_hold;
  int          t, pop_count;
  logic [31:0] prev_word, last_hs_word;
  bit          m_inframe;
  int          m_cnt;
  logic [31:0] m_acc;

  // Framing model: marker starts a word, four bytes complete it, anything else is an error.
  task automatic push_byte(input logic [8:0] b);
    fifo_q.push_back(b);
    if (emp_mode == 0) fifo_empty_I = 1'b0;
    if (b[8]) begin
      if (m_inframe) exp_err++;
      m_inframe = 1'b1;
      m_acc     = {24'h0, b[7:0]};
      m_cnt     = 1;
    end else if (!m_inframe) begin
      exp_err++;
    end else begin
      m_acc = m_acc | ({24'h0, b[7:0]} << (8 * m_cnt));
      m_cnt++;
      if (m_cnt == 4) begin
        exp_q.push_back(m_acc);
        m_inframe = 1'b0;
      end
    end
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    m_inframe = 1'b0; m_cnt = 0; m_acc = 32'h0;
    exp_err = 0; err_seen = 0; hs_total = 0; prev_hold = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    case (rdy_mode)
      0:       word_ready_I = 1'b0;
      1:       word_ready_I = 1'b1;
      default: word_ready_I = 1'($urandom_range(0, 1));
    endcase
    if (sync_err_O) err_seen++;
    n_cmp++;
    if (fifo_pop_O && (fifo_empty_I || word_valid_O)) begin
      n_bad++;
      $display("FAIL pop_guard t=%0d pop=%b empty=%b valid=%b required pop=0", t, fifo_pop_O, fifo_empty_I, word_valid_O);
    end
    if (prev_hold && word_valid_O) begin
      n_cmp++;
      if (word_O !== prev_word) begin
        n_bad++;
        $display("FAIL word_stable t=%0d got %h required %h", t, word_O, prev_word);
      end
    end
    if (word_valid_O && word_ready_I) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL extra_word t=%0d got %h required none", t, word_O);
      end else begin
        logic [31:0] w;
        w = exp_q.pop_front();
        if (word_O !== w) begin
          n_bad++;
          $display("FAIL word_data t=%0d got %h required %h", t, word_O, w);
        end
      end
      last_hs_word = word_O;
      hs_total++;
    end
    prev_hold = word_valid_O && !word_ready_I;
    prev_word = word_O;
    last_pop  = fifo_pop_O;
    if (fifo_pop_O) pop_count++;
    @(posedge clk);
    #1;
    t++;
    if (last_pop) fifo_data_I = (fifo_q.size() > 0) ? fifo_q.pop_front() : 9'h000;
    emp_phase    = ~emp_phase;
    fifo_empty_I = (fifo_q.size() == 0) || (emp_mode == 1 && emp_phase) ||
                   (emp_mode == 2 && $urandom_range(0, 1) == 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0 || word_valid_O) && n < 3000) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= 3000) begin
      n_bad++;
      $display("FAIL %s_timeout got %0d cycles required <3000", name, n);
    end
    repeat (4) tick();
    n_cmp++;
    if (err_seen !== exp_err) begin
      n_bad++;
      $display("FAIL %s_sync_err got %0d pulses required %0d", name, err_seen, exp_err);
    end
    n_cmp++;
    if (word_cnt_O !== 16'(hs_total)) begin
      n_bad++;
      $display("FAIL %s_word_cnt got %0d required %0d", name, word_cnt_O, hs_total);
    end
  endtask

  task automatic apply_reset();
    reset_I = 1'b0;
    clear_model();
    fifo_empty_I = 1'b1;
    repeat (3) tick();
    reset_I = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_I = 1'b0; rdy_mode = 0; emp_mode = 0; fifo_data_I = 9'h0; word_ready_I = 1'b0;
    clear_model();
    fifo_empty_I = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if ({fifo_pop_O, word_valid_O, sync_err_O} !== 3'b000 || word_O !== 32'h0 || word_cnt_O !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_state got pop=%b valid=%b err=%b word=%h cnt=%0d required all 0",
               fifo_pop_O, word_valid_O, sync_err_O, word_O, word_cnt_O);
    end
    fifo_empty_I = 1'b1;
    apply_reset();
  endtask

  task automatic test_basic();
    int pops[$];
    int first_valid;
    first_valid = -1;
    rdy_mode = 0; emp_mode = 0;
    push_byte(9'h178); push_byte(9'h056); push_byte(9'h034); push_byte(9'h012);
    for (int i = 0; i < 20 && first_valid < 0; i++) begin
      tick();
      if (last_pop) pops.push_back(t - 1);
      if (word_valid_O) first_valid = t - 1;
    end
    n_cmp++;
    if (pops.size() != 4 || pops[pops.size()-1] - pops[0] != 3) begin
      n_bad++;
      $display("FAIL basic_pops got %0d pops required 4 consecutive", pops.size());
    end
    n_cmp++;
    if (pops.size() == 0 || first_valid != pops[pops.size()-1] + 1) begin
      n_bad++;
      $display("FAIL basic_latency got valid at %0d required one cycle after last sample", first_valid);
    end
    n_cmp++;
    if (word_O !== 32'h12345678) begin
      n_bad++;
      $display("FAIL basic_word got %h required 12345678", word_O);
    end
    rdy_mode = 1;
    drain("basic");
    n_cmp++;
    if (word_cnt_O !== 16'd1) begin
      n_bad++;
      $display("FAIL basic_cnt got %0d required 1", word_cnt_O);
    end
  endtask

  task automatic test_hold();
    logic [31:0] held;
    int n;
    rdy_mode = 0; emp_mode = 0; n = 0;
    push_byte(9'h1A5); push_byte(9'h0C3); push_byte(9'h07E); push_byte(9'h011);
    push_byte(9'h101); push_byte(9'h002); push_byte(9'h003); push_byte(9'h004);
    while (!word_valid_O && n < 30) begin tick(); n++; end
    held = word_O;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (fifo_pop_O !== 1'b0 || word_O !== held || word_valid_O !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_cycle%0d got pop=%b valid=%b word=%h required pop=0 valid=1 word=%h",
                 i, fifo_pop_O, word_valid_O, word_O, held);
      end
    end
    rdy_mode = 1;
    tick();
    n_cmp++;
    if (word_valid_O !== 1'b0 || fifo_pop_O !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_release got valid=%b pop=%b required valid=0 pop=1", word_valid_O, fifo_pop_O);
    end
    drain("hold");
  endtask

  task automatic test_sync_err();
    int e0;
    rdy_mode = 1; emp_mode = 0; e0 = err_seen;
    push_byte(9'h011); push_byte(9'h022);
    push_byte(9'h1AA); push_byte(9'h0BB); push_byte(9'h0CC); push_byte(9'h0DD);
    drain("sync_err");
    n_cmp++;
    if (err_seen - e0 != 2 || last_hs_word !== 32'hDDCCBBAA) begin
      n_bad++;
      $display("FAIL sync_err_word got %0d pulses word %h required 2 pulses word DDCCBBAA", err_seen - e0, last_hs_word);
    end
  endtask

  task automatic test_early_marker();
    int e0;
    rdy_mode = 1; emp_mode = 0; e0 = err_seen;
    push_byte(9'h101); push_byte(9'h002);
    push_byte(9'h1EF); push_byte(9'h0BE); push_byte(9'h0AD); push_byte(9'h0DE);
    drain("early");
    n_cmp++;
    if (err_seen - e0 != 1 || last_hs_word !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL early_word got %0d pulses word %h required 1 pulse word DEADBEEF", err_seen - e0, last_hs_word);
    end
  endtask

  task automatic test_empty_toggle();
    rdy_mode = 1; emp_mode = 1;
    for (int w = 0; w < 3; w++) begin
      push_byte({1'b1, 8'($urandom)});
      for (int b = 0; b < 3; b++) push_byte({1'b0, 8'($urandom)});
    end
    drain("empty_toggle");
    emp_mode = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    rdy_mode = 0; emp_mode = 0; pop_count = 0; n = 0;
    push_byte(9'h155); push_byte(9'h066); push_byte(9'h077); push_byte(9'h088);
    push_byte(9'h199);
    while (pop_count < 2 && n < 20) begin tick(); n++; end
    tick();
    reset_I = 1'b0;
    #1;
    n_cmp++;
    if (fifo_pop_O !== 1'b0 || word_valid_O !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid got pop=%b valid=%b empty=%b required pop=0 valid=0", fifo_pop_O, word_valid_O, fifo_empty_I);
    end
    clear_model();
    fifo_empty_I = 1'b1;
    repeat (2) tick();
    reset_I = 1'b1;
    tick();
    push_byte(9'h1F0); push_byte(9'h0E1); push_byte(9'h0D2); push_byte(9'h0C3);
    n = 0;
    while (!word_valid_O && n < 30) begin tick(); n++; end
    n_cmp++;
    if (word_cnt_O !== 16'd0 || word_O !== 32'hC3D2E1F0) begin
      n_bad++;
      $display("FAIL reset_fresh got cnt=%0d word=%h required cnt=0 word C3D2E1F0", word_cnt_O, word_O);
    end
    rdy_mode = 1;
    drain("reset_mid");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      rdy_mode = 2;
      emp_mode = r % 3;
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 9) < 8) begin
          push_byte({1'b1, 8'($urandom)});
          for (int b = 0; b < 3; b++) push_byte({1'b0, 8'($urandom)});
        end else begin
          for (int b = 0; b < int'($urandom_range(1, 3)); b++) push_byte(9'($urandom));
        end
      end
      drain("random");
    end
    emp_mode = 0;
  endtask

  initial begin
    t = 0; pop_count = 0; emp_phase = 1'b0; last_hs_word = 32'h0; prev_word = 32'h0;
    test_reset();
    test_basic();
    test_hold();
    test_sync_err();
    test_early_marker();
    test_empty_toggle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
